logs_prog_divider: RTL and testbench
====================================

LOGS_PROG_DIVIDER -- requirements
Module: logs_prog_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of divisor and counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4: divisor after reset, legal 1..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port sync_clr  input  1  synchronous phase clear, restarts period.
REQ-007 SHALL have port div_load  input  1  one-cycle strobe capturing div_in.
REQ-008 SHALL have port div_in  input  WIDTH  requested divisor N.
REQ-009 SHALL have port tick  output  1  registered, HIGH one cycle per period.
REQ-010 SHALL have port sq  output  1  registered square wave, duty ceil(N/2)/N.
REQ-011 SHALL have port pending  output  1  a loaded divisor is awaiting application.
REQ-012 SHALL have port count  output  WIDTH  current counter value.
REQ-013 SHALL have port div_cur  output  WIDTH  divisor currently in effect.

Function
REQ-014 SHALL hold internal state: counter, cur_div, pend_div, pend flag; count=counter, div_cur=cur_div, pending=pend.
REQ-015 SHALL clamp any captured divisor of 0 to 1; values 1..2^WIDTH-1 pass unchanged.
REQ-016 On div_load, SHALL set pend_div=clamp(div_in), pend=1 at the edge; a later load overwrites pend_div before application.
REQ-017 Wrap condition SHALL be counter >= cur_div-1.
REQ-018 With en=1, sync_clr=0: tick <= (counter==0); sq <= (counter < ceil(cur_div/2)); counter <= wrap ? 0 : counter+1.
REQ-019 tick/sq SHALL lag the counter state by one cycle (tick HIGH in the cycle after counter was 0).
REQ-020 At a wrap edge with pend=1 (set before that edge), SHALL set cur_div=pend_div, pend=0; new divisor governs the next period.
REQ-021 div_load coinciding with an applying wrap edge: cur_div takes the previous pend_div; new value stored, pend stays 1.
REQ-022 With en=0, sync_clr=0: counter and sq hold, tick <= 0.
REQ-023 With en=0 and pend=1: cur_div=pend_div, pend=0, counter=0 at the next edge (immediate application while stopped).
REQ-024 sync_clr=1 SHALL take priority over en: counter <= 0, tick <= 0, sq <= 0; if pend=1, apply pend_div and clear pend at that edge.
REQ-025 div_load in the same cycle as sync_clr or stopped-apply: captured into pend_div, pend stays 1, applies at the next opportunity.
REQ-026 N=1 SHALL give tick HIGH every enabled cycle and sq constantly 1 after the first enabled edge.
REQ-027 Counter SHALL never exceed cur_div-1 and never wrap through 2^WIDTH.

Reset
REQ-028 rst_n=0 at an edge SHALL set counter=0, cur_div=DEFAULT_DIV, pend_div=DEFAULT_DIV, pend=0, tick=0, sq=0, overriding all other inputs.
REQ-029 Reset mid-period or with pend=1 SHALL discard the pending divisor.

Verification (WIDTH=8, DEFAULT_DIV=4)
REQ-030 Reset, then en=1 constantly -> count 0,1,2,3,0...; tick 1,0,0,0 repeating from the first enabled edge; sq 1,1,0,0 repeating.
REQ-031 Load div_in=6 while count=1 -> pending=1; current period ends at count=3; next period 0..5; div_cur=6, pending=0 after that wrap; sq 1,1,1,0,0,0.
REQ-032 div_in=0 loaded, en=1 -> after application div_cur=1, tick=1 every cycle, sq=1, count=0.
REQ-033 en=0 for 3 cycles at count=2 -> count stays 2, tick=0, sq holds; on resume count continues 3,0; load div_in=5 while stopped -> next edge div_cur=5, count=0, pending=0.
REQ-034 sync_clr pulse at count=2 with en=1 -> next edge count=0, tick=0, sq=0; following edge tick=1, count=1.
REQ-035 rst_n=0 one cycle while pending=1 at count=3 -> count=0, div_cur=4, pending=0, tick=0, sq=0.

Source files
------------

// File: rtl/logs_prog_divider.sv
// Programmable clock-enable divider: one-cycle tick per N-cycle period and a square wave.
// A newly loaded divisor waits for a period boundary, or applies at once while stopped or cleared.
module logs_prog_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick,
    output logic             sq,
    output logic             pending,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_cur
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] counter_reg, counter_next;
    logic [WIDTH-1:0] cur_div_reg, cur_div_next;
    logic [WIDTH-1:0] pend_div_reg, pend_div_next;
    logic             pend_reg, pend_next;
    logic             tick_reg, tick_next;
    logic             sq_reg, sq_next;

    logic [WIDTH-1:0] div_in_clamped;
    logic [WIDTH:0]   half_div;
    logic             wrap;
    logic             apply;

    // A zero divisor would never wrap; treat it as divide-by-one.
    assign div_in_clamped = (div_in == '0) ? ONE : div_in;
    assign half_div       = ({1'b0, cur_div_reg} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    assign wrap           = (counter_reg >= (cur_div_reg - ONE));

    always_comb begin
        counter_next  = counter_reg;
        cur_div_next  = cur_div_reg;
        pend_div_next = pend_div_reg;
        pend_next     = pend_reg;
        tick_next     = tick_reg;
        sq_next       = sq_reg;
        apply         = 1'b0;

        if (sync_clr) begin
            counter_next = '0;
            tick_next    = 1'b0;
            sq_next      = 1'b0;
            apply        = pend_reg;
        end else if (!en) begin
            tick_next = 1'b0;
            if (pend_reg) begin
                counter_next = '0;
                apply        = 1'b1;
            end
        end else begin
            tick_next = (counter_reg == '0);
            sq_next   = ({1'b0, counter_reg} < half_div);
            if (wrap) begin
                counter_next = '0;
                apply        = pend_reg;
            end else begin
                counter_next = counter_reg + ONE;
            end
        end

        if (apply) begin
            cur_div_next = pend_div_reg;
            pend_next    = 1'b0;
        end

        // A load on the same edge as an apply is kept for the next opportunity.
        if (div_load) begin
            pend_div_next = div_in_clamped;
            pend_next     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_reg  <= '0;
            cur_div_reg  <= RESET_DIV;
            pend_div_reg <= RESET_DIV;
            pend_reg     <= 1'b0;
            tick_reg     <= 1'b0;
            sq_reg       <= 1'b0;
        end else begin
            counter_reg  <= counter_next;
            cur_div_reg  <= cur_div_next;
            pend_div_reg <= pend_div_next;
            pend_reg     <= pend_next;
            tick_reg     <= tick_next;
            sq_reg       <= sq_next;
        end
    end

    assign tick    = tick_reg;
    assign sq      = sq_reg;
    assign pending = pend_reg;
    assign count   = counter_reg;
    assign div_cur = cur_div_reg;

endmodule

// File: tb/tb_logs_prog_divider.sv
// Directed and randomized checks of logs_prog_divider against a cycle-level reference model.
module tb_logs_prog_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync_clr = 1'b0;
    logic       div_load = 1'b0;
    logic [7:0] div_in = 8'd0;
    logic       tick, sq, pending;
    logic [7:0] count, div_cur;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_count, m_div, m_pdiv;
    bit m_pend, m_tick, m_sq;

    logs_prog_divider #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .div_load(div_load), .div_in(div_in), .tick(tick), .sq(sq),
        .pending(pending), .count(count), .div_cur(div_cur)
    );

    always #5 clk = ~clk;

    // Next state from the behavioural rules, using the inputs present before the edge.
    task automatic model_update();
        bit apply;
        int newdiv;
        apply  = 1'b0;
        newdiv = (div_in == 8'd0) ? 1 : int'(div_in);
        if (!rst_n) begin
            m_count = 0; m_div = 4; m_pdiv = 4; m_pend = 0; m_tick = 0; m_sq = 0;
            return;
        end
        if (sync_clr) begin
            m_count = 0; m_tick = 0; m_sq = 0; apply = m_pend;
        end else if (!en) begin
            m_tick = 0;
            if (m_pend) begin m_count = 0; apply = 1; end
        end else begin
            m_tick = (m_count == 0);
            m_sq   = (2 * m_count < m_div);
            if (m_count + 1 >= m_div) begin m_count = 0; apply = m_pend; end
            else m_count = m_count + 1;
        end
        if (apply) begin m_div = m_pdiv; m_pend = 0; end
        if (div_load) begin m_pdiv = newdiv; m_pend = 1; end
    endtask

    task automatic cmp(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        cmp({tag, ".count"},   int'(count),   m_count);
        cmp({tag, ".div_cur"}, int'(div_cur), m_div);
        cmp({tag, ".pending"}, int'(pending), int'(m_pend));
        cmp({tag, ".tick"},    int'(tick),    int'(m_tick));
        cmp({tag, ".sq"},      int'(sq),      int'(m_sq));
    endtask

    task automatic step(string tag);
        model_update();
        @(posedge clk);
        #1;
        check_all(tag);
        div_load = 1'b0;
        sync_clr = 1'b0;
    endtask

    // Advance with current inputs until count reaches target, bounded.
    task automatic run_until(string tag, int target);
        for (int i = 0; i < 300; i++) begin
            if (int'(count) == target) break;
            step(tag);
        end
        cmp({tag, ".reach"}, int'(count), target);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        step("reset");
        step("reset2");
        cmp("reset.div_lit", int'(div_cur), 4);
        rst_n = 1'b1;

        // Free-running divide by 4
        en = 1'b1;
        for (int i = 0; i < 8; i++) step("div4");

        // Load 6 mid-period
        run_until("to1", 1);
        div_in = 8'd6; div_load = 1'b1;
        step("load6");
        cmp("load6.pend_lit", int'(pending), 1);
        for (int i = 0; i < 14; i++) step("div6");
        cmp("div6.div_lit", int'(div_cur), 6);

        // Load 0 -> clamped to 1
        div_in = 8'd0; div_load = 1'b1;
        step("load0");
        for (int i = 0; i < 10; i++) step("div1");
        cmp("div1.div_lit", int'(div_cur), 1);

        // Back to 4, then stop at count 2
        div_in = 8'd4; div_load = 1'b1;
        step("load4");
        run_until("to2", 2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step("stopped");
        cmp("stopped.count_lit", int'(count), 2);
        en = 1'b1;
        step("resume3");
        step("resume0");
        en = 1'b0;
        div_in = 8'd5; div_load = 1'b1;
        step("load5_stopped");
        step("apply5_stopped");
        cmp("apply5.div_lit", int'(div_cur), 5);
        en = 1'b1;
        for (int i = 0; i < 6; i++) step("div5");

        // Synchronous clear at count 2
        run_until("to2b", 2);
        sync_clr = 1'b1;
        step("clr");
        step("after_clr");
        cmp("after_clr.tick_lit", int'(tick), 1);

        // Load then reset while pending at count 3
        run_until("to1b", 1);
        div_in = 8'd9; div_load = 1'b1;
        step("load9");
        run_until("to3", 3);
        rst_n = 1'b0;
        step("rst_pend");
        cmp("rst_pend.pend_lit", int'(pending), 0);
        rst_n = 1'b1;

        // Load coinciding with applying wrap
        div_in = 8'd3; div_load = 1'b1;
        step("loadA");
        run_until("to3c", 3);
        div_in = 8'd7; div_load = 1'b1;
        step("load_at_wrap");
        for (int i = 0; i < 12; i++) step("post_wrap_load");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            en       = ($urandom_range(0, 7) != 0);
            sync_clr = ($urandom_range(0, 19) == 0);
            div_load = ($urandom_range(0, 9) == 0);
            div_in   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
